axi_tdd_ng_cfg_loader: RTL and testbench

// Register-bus initiator that programs and arms one axi_tdd_ng core over its up_* register interface.
// - Checks the core identification.
// - Disables the core, writes the frame/channel configuration and enables it.
// - Polls STATUS until the core leaves IDLE.
// - Sits between a local control FSM or sequencer and the TDD core's up_* slave port. Replaces software bring-up in standalone designs.

---
 rtl/axi_tdd_ng_cfg_loader.sv | 271 +++++++++++++++++++++++++++
 tb/tb_axi_tdd_ng_cfg_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tdd_ng_cfg_loader.sv
// Register-bus initiator that identifies, disables, configures and re-arms one
// axi_tdd_ng core through its up_* slave port, then polls STATUS until armed.
module axi_tdd_ng_cfg_loader #(
  parameter int CHANNEL_COUNT  = 8,
  parameter int REGISTER_WIDTH = 32,
  parameter int ACK_TIMEOUT    = 255,
  parameter int POLL_MAX       = 64
) (
  input  logic                                     up_clk,
  input  logic                                     up_rstn,
  input  logic                                     start,
  input  logic [31:0]                              cfg_control,
  input  logic [CHANNEL_COUNT-1:0]                 cfg_ch_enable,
  input  logic [CHANNEL_COUNT-1:0]                 cfg_ch_pol,
  input  logic [REGISTER_WIDTH-1:0]                cfg_burst,
  input  logic [REGISTER_WIDTH-1:0]                cfg_delay,
  input  logic [REGISTER_WIDTH-1:0]                cfg_frame,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  cfg_ch_on,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  cfg_ch_off,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error,
  output logic [1:0]                               error_code,
  output logic                                     up_wreq,
  output logic [7:0]                               up_waddr,
  output logic [REGISTER_WIDTH-1:0]                up_wdata,
  input  logic                                     up_wack,
  output logic                                     up_rreq,
  output logic [7:0]                               up_raddr,
  input  logic [REGISTER_WIDTH-1:0]                up_rdata,
  input  logic                                     up_rack
);

  localparam int CW = $clog2(CHANNEL_COUNT + 1);
  localparam int TW = 17;
  localparam logic [REGISTER_WIDTH-1:0] ID_VALUE = REGISTER_WIDTH'(32'h5444444E);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_RD, S_DIS_WR, S_CFG_WR, S_CH_WR, S_EN_WR, S_POLL, S_FINISH
  } state_t;

  state_t                              state;
  logic                                pend;
  logic                                pend_rd;
  logic [TW-1:0]                       tmo_cnt;
  logic [TW-1:0]                       poll_cnt;
  logic [2:0]                          cfg_idx;
  logic [CW-1:0]                       ch_idx;
  logic                                ch_half;
  logic [31:0]                         ctrl_reg;
  logic [CHANNEL_COUNT-1:0]            en_sh;
  logic [CHANNEL_COUNT-1:0]            pol_reg;
  logic [REGISTER_WIDTH-1:0]           burst_reg;
  logic [REGISTER_WIDTH-1:0]           delay_reg;
  logic [REGISTER_WIDTH-1:0]           frame_reg;
  // Channel offsets are shifted down as channels are consumed, so the
  // current channel always sits in the lowest slot.
  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] on_sh;
  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] off_sh;

  logic [REGISTER_WIDTH-1:0] en_ext;
  logic [REGISTER_WIDTH-1:0] pol_ext;
  logic                      ack_ok;
  logic                      tmo_hit;
  logic                      fin;
  logic [1:0]                fin_code;
  logic                      issue;
  logic                      issue_rd;
  logic [7:0]                issue_addr;
  logic [REGISTER_WIDTH-1:0] issue_data;

  // Zero-extend (or truncate) the channel masks to register width.
  genvar gi;
  generate
    for (gi = 0; gi < REGISTER_WIDTH; gi++) begin : g_ext
      if (gi < CHANNEL_COUNT) begin : g_ch
        assign en_ext[gi]  = en_sh[gi];
        assign pol_ext[gi] = pol_reg[gi];
      end else begin : g_zero
        assign en_ext[gi]  = 1'b0;
        assign pol_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Only the ack matching the outstanding direction completes it.
  assign ack_ok  = pend & (pend_rd ? up_rack : up_wack);
  assign tmo_hit = pend & ~ack_ok & (tmo_cnt >= TW'(ACK_TIMEOUT));

  // Terminal conditions: timeout, ID mismatch, poll success or exhaustion.
  always_comb begin
    fin      = 1'b0;
    fin_code = 2'd0;
    if (tmo_hit) begin
      fin      = 1'b1;
      fin_code = 2'd2;
    end else if (ack_ok && state == S_ID_RD && up_rdata != ID_VALUE) begin
      fin      = 1'b1;
      fin_code = 2'd1;
    end else if (ack_ok && state == S_POLL) begin
      if (up_rdata[1:0] != 2'b00) begin
        fin = 1'b1;
      end else if ((poll_cnt + TW'(1)) >= TW'(POLL_MAX)) begin
        fin      = 1'b1;
        fin_code = 2'd3;
      end
    end
  end

  // Transaction the current state wants to issue next.
  always_comb begin
    issue      = 1'b1;
    issue_rd   = 1'b0;
    issue_addr = 8'h00;
    issue_data = '0;
    case (state)
      S_ID_RD: begin
        issue_rd   = 1'b1;
        issue_addr = 8'h03;
      end
      S_DIS_WR: issue_addr = 8'h10;
      S_CFG_WR: begin
        issue_addr = 8'h11 + {5'b0, cfg_idx};
        case (cfg_idx)
          3'd0:    issue_data = en_ext;
          3'd1:    issue_data = pol_ext;
          3'd2:    issue_data = burst_reg;
          3'd3:    issue_data = delay_reg;
          default: issue_data = frame_reg;
        endcase
      end
      S_CH_WR: begin
        issue      = (ch_idx != CW'(CHANNEL_COUNT)) && en_sh[0];
        issue_addr = 8'h20 + (8'(ch_idx) << 1) + {7'b0, ch_half};
        issue_data = ch_half ? off_sh[REGISTER_WIDTH-1:0] : on_sh[REGISTER_WIDTH-1:0];
      end
      S_EN_WR: begin
        issue_addr = 8'h10;
        issue_data = REGISTER_WIDTH'(ctrl_reg | 32'd1);
      end
      S_POLL: begin
        issue_rd   = 1'b1;
        issue_addr = 8'h18;
      end
      default: issue = 1'b0;
    endcase
  end

  // Sequencer: one outstanding transaction, registered bus and status outputs.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state      <= S_IDLE;
      pend       <= 1'b0;
      pend_rd    <= 1'b0;
      tmo_cnt    <= '0;
      poll_cnt   <= '0;
      cfg_idx    <= '0;
      ch_idx     <= '0;
      ch_half    <= 1'b0;
      ctrl_reg   <= '0;
      en_sh      <= '0;
      pol_reg    <= '0;
      burst_reg  <= '0;
      delay_reg  <= '0;
      frame_reg  <= '0;
      on_sh      <= '0;
      off_sh     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= 2'd0;
      up_wreq    <= 1'b0;
      up_waddr   <= 8'h00;
      up_wdata   <= '0;
      up_rreq    <= 1'b0;
      up_raddr   <= 8'h00;
    end else begin
      done    <= 1'b0;
      up_wreq <= 1'b0;
      up_rreq <= 1'b0;
      if (fin) begin
        state      <= S_FINISH;
        pend       <= 1'b0;
        done       <= 1'b1;
        busy       <= 1'b0;
        error      <= (fin_code != 2'd0);
        error_code <= fin_code;
      end else if (state == S_IDLE) begin
        if (start) begin
          ctrl_reg   <= cfg_control;
          en_sh      <= cfg_ch_enable;
          pol_reg    <= cfg_ch_pol;
          burst_reg  <= cfg_burst;
          delay_reg  <= cfg_delay;
          frame_reg  <= cfg_frame;
          on_sh      <= cfg_ch_on;
          off_sh     <= cfg_ch_off;
          busy       <= 1'b1;
          error      <= 1'b0;
          error_code <= 2'd0;
          pend       <= 1'b0;
          state      <= S_ID_RD;
        end
      end else if (state == S_FINISH) begin
        state <= S_IDLE;
      end else if (!pend) begin
        if (issue) begin
          pend    <= 1'b1;
          pend_rd <= issue_rd;
          tmo_cnt <= '0;
          if (issue_rd) begin
            up_rreq  <= 1'b1;
            up_raddr <= issue_addr;
          end else begin
            up_wreq  <= 1'b1;
            up_waddr <= issue_addr;
            up_wdata <= issue_data;
          end
        end else if (state == S_CH_WR) begin
          // Disabled channel (or past the last one): skip without a bus cycle.
          if (ch_idx == CW'(CHANNEL_COUNT)) begin
            state <= S_EN_WR;
          end else begin
            ch_idx <= ch_idx + CW'(1);
            en_sh  <= en_sh >> 1;
            on_sh  <= on_sh >> REGISTER_WIDTH;
            off_sh <= off_sh >> REGISTER_WIDTH;
          end
        end
      end else if (ack_ok) begin
        pend <= 1'b0;
        case (state)
          S_ID_RD:  state <= S_DIS_WR;
          S_DIS_WR: begin
            state   <= S_CFG_WR;
            cfg_idx <= 3'd0;
          end
          S_CFG_WR: begin
            if (cfg_idx == 3'd4) begin
              state   <= S_CH_WR;
              ch_idx  <= '0;
              ch_half <= 1'b0;
            end else begin
              cfg_idx <= cfg_idx + 3'd1;
            end
          end
          S_CH_WR: begin
            if (ch_half) begin
              ch_half <= 1'b0;
              ch_idx  <= ch_idx + CW'(1);
              en_sh   <= en_sh >> 1;
              on_sh   <= on_sh >> REGISTER_WIDTH;
              off_sh  <= off_sh >> REGISTER_WIDTH;
            end else begin
              ch_half <= 1'b1;
            end
          end
          S_EN_WR: begin
            state    <= S_POLL;
            poll_cnt <= '0;
          end
          S_POLL:  poll_cnt <= poll_cnt + TW'(1);
          default: state <= S_IDLE;
        endcase
      end else if (tmo_cnt != {TW{1'b1}}) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_tdd_ng_cfg_loader.sv
// Self-checking bench: a behavioural up_* slave records every transaction and
// the results are compared with a list-based model of the load sequence.
`timescale 1ns/1ps
module tb_axi_tdd_ng_cfg_loader;
  localparam int CC = 8;
  localparam int RW = 32;
  localparam int AT = 16;
  localparam int PM = 4;
  localparam logic [RW-1:0] CORE_ID = 32'h5444444E;

  logic up_clk = 1'b0;
  logic up_rstn;
  logic start;
  logic [31:0] cfg_control;
  logic [CC-1:0] cfg_ch_enable, cfg_ch_pol;
  logic [RW-1:0] cfg_burst, cfg_delay, cfg_frame;
  logic [CC*RW-1:0] cfg_ch_on, cfg_ch_off;
  logic busy, done, error;
  logic [1:0] error_code;
  logic up_wreq, up_wack, up_rreq, up_rack;
  logic [7:0] up_waddr, up_raddr;
  logic [RW-1:0] up_wdata, up_rdata;

  axi_tdd_ng_cfg_loader #(
    .CHANNEL_COUNT(CC), .REGISTER_WIDTH(RW), .ACK_TIMEOUT(AT), .POLL_MAX(PM)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn), .start(start),
    .cfg_control(cfg_control), .cfg_ch_enable(cfg_ch_enable), .cfg_ch_pol(cfg_ch_pol),
    .cfg_burst(cfg_burst), .cfg_delay(cfg_delay), .cfg_frame(cfg_frame),
    .cfg_ch_on(cfg_ch_on), .cfg_ch_off(cfg_ch_off),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );

  always #5 up_clk = ~up_clk;

  int checks = 0;
  int fails = 0;

  // slave behaviour controls and transaction logs
  logic [RW-1:0] id_value;
  int            withhold_wr;
  bit            spurious_rack;
  logic [RW-1:0] status_q[$];
  logic [7:0]    wr_addr_q[$];
  logic [RW-1:0] wr_data_q[$];
  logic [7:0]    rd_addr_q[$];
  int            stab_err;
  int            done_count = 0;

  // model outputs
  logic [7:0]    exp_wa[$];
  logic [RW-1:0] exp_wd[$];
  logic [7:0]    exp_ra[$];

  always @(negedge up_clk) if (done === 1'b1) done_count++;

  // Behavioural register slave: 1..3 cycle latency, optional withheld write ack.
  initial begin : responder
    logic [7:0] a;
    logic [RW-1:0] d;
    int lat;
    up_wack = 1'b0; up_rack = 1'b0; up_rdata = '0;
    forever begin
      @(negedge up_clk);
      if (up_wreq === 1'b1) begin
        a = up_waddr; d = up_wdata;
        wr_addr_q.push_back(a); wr_data_q.push_back(d);
        if (int'(wr_addr_q.size()) - 1 != withhold_wr) begin
          lat = spurious_rack ? 2 : $urandom_range(3, 1);
          if (spurious_rack) up_rack = 1'b1;
          for (int k = 0; k < lat; k++) begin
            @(negedge up_clk);
            up_rack = 1'b0;
            if (up_rstn && (up_waddr !== a || up_wdata !== d)) stab_err++;
          end
          up_wack = 1'b1;
          @(negedge up_clk);
          up_wack = 1'b0;
        end
      end else if (up_rreq === 1'b1) begin
        a = up_raddr;
        rd_addr_q.push_back(a);
        lat = $urandom_range(3, 1);
        for (int k = 0; k < lat; k++) begin
          @(negedge up_clk);
          if (up_rstn && up_raddr !== a) stab_err++;
        end
        if (a == 8'h03) d = id_value;
        else if (status_q.size() > 0) d = status_q.pop_front();
        else d = 32'h1;
        up_rdata = d; up_rack = 1'b1;
        @(negedge up_clk);
        up_rack = 1'b0; up_rdata = $urandom;
      end
    end
  end

  task automatic randomize_cfg();
    cfg_control = $urandom;
    cfg_ch_enable = CC'($urandom);
    cfg_ch_pol = CC'($urandom);
    cfg_burst = $urandom; cfg_delay = $urandom; cfg_frame = $urandom;
    for (int n = 0; n < CC; n++) begin
      cfg_ch_on[n*RW +: RW] = $urandom;
      cfg_ch_off[n*RW +: RW] = $urandom;
    end
  endtask

  // Expected register writes straight from the programming rules.
  function automatic void build_model();
    exp_wa.delete(); exp_wd.delete();
    exp_wa.push_back(8'h10); exp_wd.push_back('0);
    exp_wa.push_back(8'h11); exp_wd.push_back(RW'(cfg_ch_enable));
    exp_wa.push_back(8'h12); exp_wd.push_back(RW'(cfg_ch_pol));
    exp_wa.push_back(8'h13); exp_wd.push_back(cfg_burst);
    exp_wa.push_back(8'h14); exp_wd.push_back(cfg_delay);
    exp_wa.push_back(8'h15); exp_wd.push_back(cfg_frame);
    for (int n = 0; n < CC; n++) begin
      if (cfg_ch_enable[n]) begin
        exp_wa.push_back(8'(32 + 2*n));     exp_wd.push_back(cfg_ch_on[n*RW +: RW]);
        exp_wa.push_back(8'(32 + 2*n + 1)); exp_wd.push_back(cfg_ch_off[n*RW +: RW]);
      end
    end
    exp_wa.push_back(8'h10); exp_wd.push_back(RW'(cfg_control | 32'd1));
  endfunction

  // Expected reads: ID, then STATUS until a non-idle value or PM reads.
  function automatic void build_reads();
    exp_ra.delete();
    exp_ra.push_back(8'h03);
    for (int i = 0; i < PM; i++) begin
      exp_ra.push_back(8'h18);
      if (i < status_q.size() && status_q[i][1:0] != 2'b00) break;
      if (i >= status_q.size()) break;
    end
  endfunction

  task automatic run_seq(input int extra_start_at, output bit got, output logic busy1,
                         output logic b_at, output logic e_at, output logic [1:0] c_at);
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); stab_err = 0;
    @(negedge up_clk); start = 1'b1;
    @(negedge up_clk); start = 1'b0; busy1 = busy;
    got = 1'b0; b_at = 1'b1; e_at = 1'b0; c_at = 2'd0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge up_clk);
      start = (i == extra_start_at);
      if (done === 1'b1) begin
        got = 1'b1; b_at = busy; e_at = error; c_at = error_code;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge up_clk);
  endtask

  task automatic test_reset();
    up_rstn = 1'b0; start = 1'b0;
    randomize_cfg();
    id_value = CORE_ID; withhold_wr = -1; spurious_rack = 1'b0;
    repeat (3) @(negedge up_clk);
    checks++;
    if ({busy, done, error, error_code, up_wreq, up_rreq, up_waddr, up_raddr, up_wdata} !== '0) begin
      fails++; $display("FAIL reset_outputs: busy=%b done=%b err=%b code=%0d wreq=%b rreq=%b, required all 0",
                        busy, done, error, error_code, up_wreq, up_rreq);
    end
    up_rstn = 1'b1;
    repeat (3) @(negedge up_clk);
    checks++;
    if (busy !== 1'b0 || up_wreq !== 1'b0 || up_rreq !== 1'b0) begin
      fails++; $display("FAIL idle_quiet: busy=%b wreq=%b rreq=%b, required 0", busy, up_wreq, up_rreq);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit got; logic b1, b_at, e_at; logic [1:0] c_at; int dc0;
    randomize_cfg(); cfg_ch_enable = 8'h05;
    status_q.delete(); status_q.push_back(32'h2);
    build_model(); build_reads();
    dc0 = done_count;
    run_seq(-1, got, b1, b_at, e_at, c_at);
    checks++;
    if (!got || b1 !== 1'b1 || b_at !== 1'b0 || e_at !== 1'b0 || c_at !== 2'd0 || done_count - dc0 != 1) begin
      fails++; $display("FAIL basic_status: done=%b busy1=%b busy@done=%b err=%b code=%0d pulses=%0d, required 1 1 0 0 0 1",
                        got, b1, b_at, e_at, c_at, done_count - dc0);
    end
    checks++;
    if (wr_addr_q.size() != exp_wa.size() || wr_addr_q.size() != 11) begin
      fails++; $display("FAIL basic_wcount: got %0d writes, required %0d", wr_addr_q.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
        fails++; $display("FAIL basic_write[%0d]: got %h=%h, required %h=%h", i, wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
      end
    end
    checks++;
    if (rd_addr_q.size() != exp_ra.size() || stab_err != 0) begin
      fails++; $display("FAIL basic_reads: got %0d reads stab_err=%0d, required %0d reads 0", rd_addr_q.size(), stab_err, exp_ra.size());
    end
    $display("test_basic done: %0d writes %0d reads", wr_addr_q.size(), rd_addr_q.size());
  endtask

  task automatic test_id_mismatch();
    bit got; logic b1, b_at, e_at; logic [1:0] c_at;
    randomize_cfg(); id_value = 32'h12345678;
    run_seq(-1, got, b1, b_at, e_at, c_at);
    checks++;
    if (!got || e_at !== 1'b1 || c_at !== 2'd1 || b_at !== 1'b0) begin
      fails++; $display("FAIL id_status: done=%b err=%b code=%0d busy=%b, required 1 1 1 0", got, e_at, c_at, b_at);
    end
    checks++;
    if (wr_addr_q.size() != 0 || rd_addr_q.size() != 1) begin
      fails++; $display("FAIL id_traffic: got %0d writes %0d reads, required 0 and 1", wr_addr_q.size(), rd_addr_q.size());
    end
    checks++;
    if (error !== 1'b1 || error_code !== 2'd1) begin
      fails++; $display("FAIL id_sticky: err=%b code=%0d after idle, required 1 1", error, error_code);
    end
    id_value = CORE_ID;
    $display("test_id_mismatch done");
  endtask

  task automatic test_timeout();
    bit got; logic b1, b_at, e_at; logic [1:0] c_at;
    randomize_cfg(); withhold_wr = 2;
    build_model();
    while (exp_wa.size() > 3) begin void'(exp_wa.pop_back()); void'(exp_wd.pop_back()); end
    run_seq(-1, got, b1, b_at, e_at, c_at);
    repeat (20) @(negedge up_clk);
    checks++;
    if (!got || e_at !== 1'b1 || c_at !== 2'd2) begin
      fails++; $display("FAIL timeout_status: done=%b err=%b code=%0d, required 1 1 2", got, e_at, c_at);
    end
    checks++;
    if (wr_addr_q.size() != 3 || rd_addr_q.size() != 1) begin
      fails++; $display("FAIL timeout_traffic: got %0d writes %0d reads, required 3 and 1", wr_addr_q.size(), rd_addr_q.size());
    end
    for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
        fails++; $display("FAIL timeout_write[%0d]: got %h=%h, required %h=%h", i, wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
      end
    end
    withhold_wr = -1;
    $display("test_timeout done");
  endtask

  task automatic test_poll();
    bit got; logic b1, b_at, e_at; logic [1:0] c_at;
    // three idle reads with random upper bits, then ARMED
    randomize_cfg();
    status_q.delete();
    for (int i = 0; i < 3; i++) status_q.push_back($urandom & 32'hFFFF_FFFC);
    status_q.push_back(($urandom & 32'hFFFF_FFFC) | 32'h1);
    build_reads();
    run_seq(-1, got, b1, b_at, e_at, c_at);
    checks++;
    if (!got || e_at !== 1'b0 || rd_addr_q.size() != 5 || rd_addr_q.size() != exp_ra.size()) begin
      fails++; $display("FAIL poll_ok: done=%b err=%b reads=%0d, required 1 0 %0d", got, e_at, rd_addr_q.size(), exp_ra.size());
    end
    for (int i = 1; i < rd_addr_q.size(); i++) begin
      checks++;
      if (rd_addr_q[i] !== 8'h18) begin
        fails++; $display("FAIL poll_addr[%0d]: got %h, required 18", i, rd_addr_q[i]);
      end
    end
    // never leaves IDLE
    status_q.delete();
    for (int i = 0; i < PM + 2; i++) status_q.push_back(32'h0);
    run_seq(-1, got, b1, b_at, e_at, c_at);
    checks++;
    if (!got || e_at !== 1'b1 || c_at !== 2'd3 || rd_addr_q.size() != PM + 1) begin
      fails++; $display("FAIL poll_exhaust: done=%b err=%b code=%0d reads=%0d, required 1 1 3 %0d",
                        got, e_at, c_at, rd_addr_q.size(), PM + 1);
    end
    status_q.delete();
    $display("test_poll done");
  endtask

  task automatic test_ignore();
    bit got; logic b1, b_at, e_at; logic [1:0] c_at;
    randomize_cfg(); spurious_rack = 1'b1;
    build_model();
    run_seq(6, got, b1, b_at, e_at, c_at);
    repeat (10) @(negedge up_clk);
    checks++;
    if (!got || e_at !== 1'b0 || busy !== 1'b0 || wr_addr_q.size() != exp_wa.size() || rd_addr_q.size() != 2) begin
      fails++; $display("FAIL ignore_status: done=%b err=%b busy=%b writes=%0d reads=%0d, required 1 0 0 %0d 2",
                        got, e_at, busy, wr_addr_q.size(), rd_addr_q.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
        fails++; $display("FAIL ignore_write[%0d]: got %h=%h, required %h=%h", i, wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
      end
    end
    spurious_rack = 1'b0;
    $display("test_ignore done");
  endtask

  task automatic test_midreset();
    bit got; logic b1, b_at, e_at; logic [1:0] c_at; int dc0;
    randomize_cfg(); cfg_ch_enable = '1;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    dc0 = done_count;
    @(negedge up_clk); start = 1'b1;
    @(negedge up_clk); start = 1'b0;
    for (int i = 0; i < 500 && wr_addr_q.size() < 8; i++) @(negedge up_clk);
    checks++;
    if (wr_addr_q.size() < 8) begin
      fails++; $display("FAIL midreset_reach: got %0d writes, required at least 8", wr_addr_q.size());
    end
    #2 up_rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, error_code, up_wreq, up_rreq, up_waddr, up_raddr, up_wdata} !== '0) begin
      fails++; $display("FAIL midreset_outputs: busy=%b waddr=%h wdata=%h, required all 0", busy, up_waddr, up_wdata);
    end
    repeat (6) @(negedge up_clk);
    up_rstn = 1'b1;
    repeat (3) @(negedge up_clk);
    checks++;
    if (done_count != dc0) begin
      fails++; $display("FAIL midreset_nodone: got %0d done pulses, required 0", done_count - dc0);
    end
    build_model();
    run_seq(-1, got, b1, b_at, e_at, c_at);
    checks++;
    if (!got || e_at !== 1'b0 || rd_addr_q.size() < 1 || rd_addr_q[0] !== 8'h03 || wr_addr_q.size() != exp_wa.size()) begin
      fails++; $display("FAIL midreset_restart: done=%b err=%b writes=%0d, required 1 0 %0d from ID read",
                        got, e_at, wr_addr_q.size(), exp_wa.size());
    end
    $display("test_midreset done");
  endtask

  task automatic test_random();
    bit got; logic b1, b_at, e_at; logic [1:0] c_at; int nz;
    for (int it = 0; it < 6; it++) begin
      randomize_cfg();
      if (it == 0) cfg_ch_enable = '0;
      if (it == 1) cfg_ch_enable = '1;
      nz = $urandom_range(3, 0);
      status_q.delete();
      for (int i = 0; i < nz; i++) status_q.push_back($urandom & 32'hFFFF_FFFC);
      status_q.push_back(($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(3, 1)));
      build_model(); build_reads();
      run_seq(-1, got, b1, b_at, e_at, c_at);
      checks++;
      if (!got || e_at !== 1'b0 || wr_addr_q.size() != exp_wa.size() || rd_addr_q.size() != exp_ra.size() || stab_err != 0) begin
        fails++; $display("FAIL random[%0d]_status: done=%b err=%b writes=%0d reads=%0d stab=%0d, required 1 0 %0d %0d 0",
                          it, got, e_at, wr_addr_q.size(), rd_addr_q.size(), stab_err, exp_wa.size(), exp_ra.size());
      end
      for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
          fails++; $display("FAIL random[%0d]_write[%0d]: got %h=%h, required %h=%h",
                            it, i, wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
        end
      end
      $display("test_random iter %0d: enable=%h writes=%0d reads=%0d", it, cfg_ch_enable, wr_addr_q.size(), rd_addr_q.size());
    end
    status_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_id_mismatch();
    test_timeout();
    test_poll();
    test_ignore();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
